dense_seq_ctrl: RTL and testbench

Command-driven sequencer that feeds the decode→dense pipeline register. It accepts one layer command at a time: weight load, forward pass, or training pass. It streams weight rows, input vectors and labels through a valid/ready beat interface and drives the register's act/dense/cost type, `load_w` and `backprop_controll` fields cycle by cycle. It signals completion after a fixed pipeline drain.

---
 rtl/dense_seq_pkg.sv | 27 ++
 rtl/seq_beat_counter.sv | 43 ++++
 rtl/dense_seq_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_dense_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_seq_pkg.sv
// dense_seq_pkg: shared types and constants for the dense sequencer slice.
//   state_e     - sequencer FSM states
//   op_e        - command opcodes presented on cmd_op
//   BP_*        - flag bit offsets above the three backprop_controll word fields
package dense_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FWD,
    ST_TRAIN,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_LOAD_W  = 2'd1,
    OP_FORWARD = 2'd2,
    OP_TRAIN   = 2'd3
  } op_e;

  localparam int BP_EN    = 0;
  localparam int BP_FIRST = 1;
  localparam int BP_LAST  = 2;
  localparam int BP_UPD   = 3;

endpackage

// File: rtl/seq_beat_counter.sv
// seq_beat_counter: loadable 16-bit up-counter with a terminal compare.
//   clk, rst_n - clock and asynchronous active-low reset
//   load       - load load_val (wins over inc)
//   load_val   - value to load
//   inc        - increment by one
//   terminal   - value compared against the current count
//   count      - current count
//   at_term    - high while count equals terminal
module seq_beat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  input  logic [15:0] terminal,
  output logic [15:0] count,
  output logic        at_term
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_term = (count_q == terminal);

endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: command-driven sequencer feeding the decode->dense register.
//   clk, rst_n                   - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          - command handshake (op, config, count, lr)
//   abort                        - drop the current command, return to IDLE
//   beat_valid/beat_ready        - data beat handshake (beat_data, beat_label)
//   act_type/dense_type/cost_type- latched config
//   w, x, label                  - registered beat payloads
//   load_w, out_valid            - one-cycle beat strobes
//   backprop_controll            - {flags, beat index, lr, count}
//   busy, done                   - activity and one-cycle completion pulse
module dense_seq_ctrl
  import dense_seq_pkg::*;
#(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int act_type_size   = 4,
  parameter int dense_type_size = 4,
  parameter int cost_type_size  = 8,
  parameter int bp_field_size   = 32,
  parameter int drain_cycles    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [act_type_size-1:0]     cmd_act,
  input  logic [dense_type_size-1:0]   cmd_dense,
  input  logic [cost_type_size-1:0]    cmd_cost,
  input  logic [15:0]                  cmd_count,
  input  logic [bp_field_size-1:0]     cmd_lr,
  input  logic                         abort,
  input  logic                         beat_valid,
  output logic                         beat_ready,
  input  logic [data_size*size-1:0]    beat_data,
  input  logic [data_size*size-1:0]    beat_label,
  output logic [act_type_size-1:0]     act_type,
  output logic [dense_type_size-1:0]   dense_type,
  output logic [cost_type_size-1:0]    cost_type,
  output logic [data_size*size-1:0]    w,
  output logic [data_size*size-1:0]    x,
  output logic [data_size*size-1:0]    label,
  output logic                         load_w,
  output logic                         out_valid,
  output logic [3*bp_field_size+3:0]   backprop_controll,
  output logic                         busy,
  output logic                         done
);

  localparam int B     = bp_field_size;
  localparam int FLAG0 = 3 * bp_field_size;

  // Reset release is re-timed to clk so every flop leaves reset on the same edge.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  state_e                       state_q, state_d;
  logic [act_type_size-1:0]     act_q, act_d;
  logic [dense_type_size-1:0]   dense_q, dense_d;
  logic [cost_type_size-1:0]    cost_q, cost_d;
  logic [data_size*size-1:0]    w_q, w_d, x_q, x_d, label_q, label_d;
  logic                         load_w_q, load_w_d;
  logic                         out_valid_q, out_valid_d;
  logic [3*B+3:0]               bp_q, bp_d;
  logic                         done_q, done_d;

  logic        cnt_load;
  logic        cnt_inc;
  logic [15:0] cnt_term;
  logic [15:0] beat_idx;
  logic        at_term;
  logic        beat_fire;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign beat_ready = (state_q == ST_LOAD) || (state_q == ST_FWD) || (state_q == ST_TRAIN);
  assign busy       = (state_q != ST_IDLE);
  assign beat_fire  = beat_valid && beat_ready;

  // One counter serves as beat index in the streaming states and as the
  // drain timer in DRAIN; only the terminal value changes with the state.
  always_comb begin
    cnt_term = bp_q[15:0] - 16'd1;
    if (state_q == ST_LOAD) begin
      cnt_term = 16'(size - 1);
    end else if (state_q == ST_DRAIN) begin
      cnt_term = 16'(drain_cycles - 1);
    end
  end

  seq_beat_counter u_beat_counter (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .load     (cnt_load),
    .load_val (16'd0),
    .inc      (cnt_inc),
    .terminal (cnt_term),
    .count    (beat_idx),
    .at_term  (at_term)
  );

  // Next-state and output decode; abort outranks a beat in the same cycle,
  // and flag bits are strobes that fall back to 0 unless a beat is taken.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    dense_d     = dense_q;
    cost_d      = cost_q;
    w_d         = w_q;
    x_d         = x_q;
    label_d     = label_q;
    load_w_d    = 1'b0;
    out_valid_d = 1'b0;
    bp_d        = bp_q;
    bp_d[FLAG0 +: 4] = 4'b0;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          act_d          = cmd_act;
          dense_d        = cmd_dense;
          cost_d         = cmd_cost;
          bp_d[0 +: B]   = B'(cmd_count);
          bp_d[B +: B]   = cmd_lr;
          bp_d[2*B +: B] = '0;
          cnt_load       = 1'b1;
          case (op_e'(cmd_op))
            OP_NOP:     done_d  = 1'b1;
            OP_LOAD_W:  state_d = ST_LOAD;
            OP_FORWARD: state_d = (cmd_count == 16'd0) ? ST_DRAIN : ST_FWD;
            OP_TRAIN:   state_d = (cmd_count == 16'd0) ? ST_DRAIN : ST_TRAIN;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat_fire) begin
          w_d      = beat_data;
          load_w_d = 1'b1;
          cnt_inc  = 1'b1;
          if (at_term) begin
            state_d  = ST_DRAIN;
            cnt_load = 1'b1;
          end
        end
      end
      ST_FWD, ST_TRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat_fire) begin
          x_d         = beat_data;
          out_valid_d = 1'b1;
          if (state_q == ST_TRAIN) begin
            label_d = beat_label;
          end
          bp_d[2*B +: B]          = B'(beat_idx);
          bp_d[FLAG0 + BP_EN]     = (state_q == ST_TRAIN);
          bp_d[FLAG0 + BP_FIRST]  = (beat_idx == 16'd0);
          bp_d[FLAG0 + BP_LAST]   = at_term;
          bp_d[FLAG0 + BP_UPD]    = (state_q == ST_TRAIN) && at_term;
          cnt_inc = 1'b1;
          if (at_term) begin
            state_d  = ST_DRAIN;
            cnt_load = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (at_term) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      act_q       <= '0;
      dense_q     <= '0;
      cost_q      <= '0;
      w_q         <= '0;
      x_q         <= '0;
      label_q     <= '0;
      load_w_q    <= 1'b0;
      out_valid_q <= 1'b0;
      bp_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      dense_q     <= dense_d;
      cost_q      <= cost_d;
      w_q         <= w_d;
      x_q         <= x_d;
      label_q     <= label_d;
      load_w_q    <= load_w_d;
      out_valid_q <= out_valid_d;
      bp_q        <= bp_d;
      done_q      <= done_d;
    end
  end

  assign act_type          = act_q;
  assign dense_type        = dense_q;
  assign cost_type         = cost_q;
  assign w                 = w_q;
  assign x                 = x_q;
  assign label             = label_q;
  assign load_w            = load_w_q;
  assign out_valid         = out_valid_q;
  assign backprop_controll = bp_q;
  assign done              = done_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb_dense_seq_ctrl: directed scoreboard bench for dense_seq_ctrl.
// Stimulus pushes the expected strobe (kind, cycle, payload) into a queue;
// a negedge monitor pops an entry for every load_w / out_valid / done pulse.
module tb_dense_seq_ctrl;

  localparam int K_LOAD  = 0;
  localparam int K_FWD   = 1;
  localparam int K_TRAIN = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int           kind;
    int           cyc;
    logic [47:0]  data;
    logic [47:0]  label;
    logic [99:0]  bp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_act;
  logic [3:0]   cmd_dense;
  logic [7:0]   cmd_cost;
  logic [15:0]  cmd_count;
  logic [31:0]  cmd_lr;
  logic         abort;
  logic         beat_valid;
  logic         beat_ready;
  logic [47:0]  beat_data;
  logic [47:0]  beat_label;
  logic [3:0]   act_type;
  logic [3:0]   dense_type;
  logic [7:0]   cost_type;
  logic [47:0]  w;
  logic [47:0]  x;
  logic [47:0]  label;
  logic         load_w;
  logic         out_valid;
  logic [99:0]  backprop_controll;
  logic         busy;
  logic         done;

  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];

  dense_seq_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_act           (cmd_act),
    .cmd_dense         (cmd_dense),
    .cmd_cost          (cmd_cost),
    .cmd_count         (cmd_count),
    .cmd_lr            (cmd_lr),
    .abort             (abort),
    .beat_valid        (beat_valid),
    .beat_ready        (beat_ready),
    .beat_data         (beat_data),
    .beat_label        (beat_label),
    .act_type          (act_type),
    .dense_type        (dense_type),
    .cost_type         (cost_type),
    .w                 (w),
    .x                 (x),
    .label             (label),
    .load_w            (load_w),
    .out_valid         (out_valid),
    .backprop_controll (backprop_controll),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [99:0] mk_bp(input logic [15:0] cnt, input logic [31:0] lr,
                                        input int idx, input bit en, input bit first,
                                        input bit last, input bit upd);
    logic [31:0] idx_w;
    idx_w = 32'(idx);
    return {upd, last, first, en, idx_w, lr, 16'h0000, cnt};
  endfunction

  function automatic exp_t mk_exp(input int kind, input int c, input logic [47:0] d,
                                  input logic [47:0] l, input logic [99:0] bp);
    exp_t e;
    e.kind = kind; e.cyc = c; e.data = d; e.label = l; e.bp = bp;
    return e;
  endfunction

  // Pops the oldest expectation and compares it with the pulse just seen.
  task automatic pop_check(input int kind, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL unexpected_%s: got pulse 1, expected 0 (cycle %0d)", name, cyc);
    end else begin
      e = sb.pop_front();
      checkOutput({name, "_kind"}, 128'(kind), 128'(e.kind));
      checkOutput({name, "_cycle"}, 128'(cyc), 128'(e.cyc));
      if (kind == K_LOAD) checkOutput({name, "_w"}, 128'(w), 128'(e.data));
      if (kind == K_FWD || kind == K_TRAIN) begin
        checkOutput({name, "_x"}, 128'(x), 128'(e.data));
        checkOutput({name, "_bp"}, 128'(backprop_controll), 128'(e.bp));
        if (kind == K_TRAIN) checkOutput({name, "_label"}, 128'(label), 128'(e.label));
      end
    end
  endtask

  always @(negedge clk) begin
    if (load_w) pop_check(K_LOAD, "load_w");
    if (out_valid) pop_check(backprop_controll[96] ? K_TRAIN : K_FWD, "out_valid");
    if (done) pop_check(K_DONE, "done");
  end

  // Presents a command and waits (bounded) for it to be taken; t = accept cycle.
  task automatic issue_cmd(input logic [1:0] op, input logic [15:0] cnt,
                           input logic [31:0] lr, output int t);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_lr = lr;
    cmd_act = 4'h5; cmd_dense = 4'h9; cmd_cost = 8'hA7;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 128'(cmd_ready), 128'd1);
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for acceptance and queues its result.
  task automatic applyStimulus(input logic [47:0] d, input logic [47:0] l, input int kind,
                               input logic [99:0] bp, output int t);
    int n = 0;
    beat_valid = 1'b1; beat_data = d; beat_label = l;
    while (!beat_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!beat_ready) checkOutput("beat_ready_timeout", 128'(beat_ready), 128'd1);
    t = cyc;
    sb.push_back(mk_exp(kind, t + 1, d, l, bp));
    @(posedge clk); #1;
    beat_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    checkOutput("scoreboard_drained", 128'(sb.size()), 128'd0);
  endtask

  task automatic check_reset_outs(input string name);
    checkOutput({name, "_outs_zero"}, 128'(|{act_type, dense_type, cost_type, w, x, label,
                load_w, out_valid, backprop_controll, busy, done}), 128'd0);
    checkOutput({name, "_cmd_ready"}, 128'(cmd_ready), 128'd1);
  endtask

  initial begin
    int t;
    logic [47:0] d;
    logic [47:0] l;

    // Reset with inputs unknown.
    rst_n = 1'b0;
    cmd_valid = 'x; cmd_op = 'x; cmd_act = 'x; cmd_dense = 'x; cmd_cost = 'x;
    cmd_count = 'x; cmd_lr = 'x; abort = 'x; beat_valid = 'x; beat_data = 'x; beat_label = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("in_reset");
    cmd_valid = 0; cmd_op = 0; cmd_act = 0; cmd_dense = 0; cmd_cost = 0;
    cmd_count = 0; cmd_lr = 0; abort = 0; beat_valid = 0; beat_data = 0; beat_label = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outs("after_reset");
    checkOutput("after_reset_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;

    // LOAD_W with three back-to-back rows.
    issue_cmd(2'd1, 16'd0, 32'h0, t);
    checkOutput("cfg_act", 128'(act_type), 128'h5);
    checkOutput("cfg_dense", 128'(dense_type), 128'h9);
    checkOutput("cfg_cost", 128'(cost_type), 128'hA7);
    checkOutput("load_busy", 128'(busy), 128'd1);
    for (int i = 1; i <= 3; i++) begin
      d = {3{16'(i)}};
      applyStimulus(d, 48'h0, K_LOAD, 100'h0, t);
    end
    sb.push_back(mk_exp(K_DONE, t + 5, 48'h0, 48'h0, 100'h0));
    wait_drain();

    // TRAIN count=2, lr=0x10, two idle cycles between beats.
    issue_cmd(2'd3, 16'd2, 32'h10, t);
    d = 48'h1111_2222_3333; l = 48'hAAAA_BBBB_CCCC;
    applyStimulus(d, l, K_TRAIN, mk_bp(16'd2, 32'h10, 0, 1, 1, 0, 0), t);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      checkOutput("gap_flags", 128'({out_valid, backprop_controll[99:96]}), 128'd0);
      checkOutput("gap_index", 128'(backprop_controll[95:64]), 128'd0);
    end
    d = 48'h4444_5555_6666; l = 48'hDDDD_EEEE_FFFF;
    applyStimulus(d, l, K_TRAIN, mk_bp(16'd2, 32'h10, 1, 1, 0, 1, 1), t);
    sb.push_back(mk_exp(K_DONE, t + 5, 48'h0, 48'h0, 100'h0));
    wait_drain();

    // FORWARD with count=0 goes straight to drain.
    issue_cmd(2'd2, 16'd0, 32'h0, t);
    sb.push_back(mk_exp(K_DONE, t + 5, 48'h0, 48'h0, 100'h0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("zero_cnt_beat_ready", 128'(beat_ready), 128'd0);
      checkOutput("zero_cnt_busy", 128'(busy), 128'd1);
    end
    wait_drain();

    // FORWARD count=5 aborted together with the third beat.
    @(posedge clk); #1;
    issue_cmd(2'd2, 16'd5, 32'h77, t);
    for (int i = 0; i < 2; i++) begin
      d = 48'h0C00_0000_0000 + 48'(i);
      applyStimulus(d, 48'h0, K_FWD, mk_bp(16'd5, 32'h77, i, 0, i == 0, 0, 0), t);
    end
    abort = 1'b1; beat_valid = 1'b1; beat_data = 48'hDEAD_DEAD_DEAD;
    @(posedge clk); #1;
    abort = 1'b0; beat_valid = 1'b0;
    checkOutput("abort_idle_cmd_ready", 128'(cmd_ready), 128'd1);
    checkOutput("abort_idle_busy", 128'(busy), 128'd0);
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_flags", 128'(backprop_controll[99:96]), 128'd0);
    checkOutput("abort_x_hold", 128'(x), 128'h0C00_0000_0001);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_no_pending", 128'(sb.size()), 128'd0);

    // Reset pulsed during TRAIN, then a NOP.
    issue_cmd(2'd3, 16'd3, 32'h20, t);
    applyStimulus(48'h0123_4567_89AB, 48'h1, K_TRAIN, mk_bp(16'd3, 32'h20, 0, 1, 1, 0, 0), t);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue_cmd(2'd0, 16'd0, 32'h0, t);
    sb.push_back(mk_exp(K_DONE, t + 1, 48'h0, 48'h0, 100'h0));
    wait_drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
